// File: rtl/threshold_monitor.sv
// rtl/threshold_monitor.sv - streaming threshold monitor with persistence filter, hysteresis and alarm FSM
//
// Purpose:
//   Compares each accepted sample against programmable high/low thresholds.
//   A run of PERSIST consecutive out-of-band samples enters an alarm state.
//   The alarm is left only once the sample is back inside the band by HYST LSBs.
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   din_valid   sample qualifier
//   din         unsigned sample
//   thr_hi      high threshold, sampled with din
//   thr_lo      low threshold, sampled with din
//   in_range    state is NORMAL
//   alarm_hi    state is HIGH
//   alarm_lo    state is LOW
//   cfg_err     last accepted sample had thr_lo > thr_hi
//   dout_valid  one-cycle pulse after each accepted sample
//   evt         one-cycle pulse on every state change
//   evt_code    state entered (0=INIT 1=NORMAL 2=HIGH 3=LOW), held between events
module threshold_monitor #(
  parameter int WIDTH   = 4,
  parameter int PERSIST = 3,
  parameter int HYST    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] thr_hi,
  input  logic [WIDTH-1:0] thr_lo,
  output logic             in_range,
  output logic             alarm_hi,
  output logic             alarm_lo,
  output logic             cfg_err,
  output logic             dout_valid,
  output logic             evt,
  output logic [1:0]       evt_code
);

  localparam int CW = $clog2(PERSIST + 1);
  localparam logic [CW-1:0]  PERSIST_C = CW'(PERSIST);
  localparam logic [WIDTH:0] HYST_X    = (WIDTH + 1)'(HYST);

  // Encoding equals the evt_code values so the entered state is reported directly.
  typedef enum logic [1:0] {
    S_INIT   = 2'd0,
    S_NORMAL = 2'd1,
    S_HIGH   = 2'd2,
    S_LOW    = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] hi_cnt_q, hi_cnt_d;
  logic [CW-1:0] lo_cnt_q, lo_cnt_d;
  logic          in_range_q, alarm_hi_q, alarm_lo_q;
  logic          cfg_err_q, dout_valid_q, evt_q;
  logic [1:0]    evt_code_q;

  logic          cfg_bad, gt, lt, exit_hi, exit_lo;
  logic [CW-1:0] hi_inc, lo_inc, hi_nxt, lo_nxt;

  always_comb begin
    cfg_bad = thr_lo > thr_hi;
    // An illegal threshold pair qualifies nothing, which also clears both counters.
    gt      = !cfg_bad && (din > thr_hi);
    lt      = !cfg_bad && (din < thr_lo);
    // One extra bit so din + HYST and thr_lo + HYST cannot wrap.
    exit_hi = ({1'b0, din} + HYST_X) <= {1'b0, thr_hi};
    exit_lo = {1'b0, din} >= ({1'b0, thr_lo} + HYST_X);

    hi_inc  = (hi_cnt_q == PERSIST_C) ? PERSIST_C : hi_cnt_q + CW'(1);
    lo_inc  = (lo_cnt_q == PERSIST_C) ? PERSIST_C : lo_cnt_q + CW'(1);
    hi_nxt  = gt ? hi_inc : '0;
    lo_nxt  = lt ? lo_inc : '0;

    state_d = state_q;
    if (!cfg_bad) begin
      case (state_q)
        S_INIT, S_NORMAL: begin
          if (hi_nxt == PERSIST_C)      state_d = S_HIGH;
          else if (lo_nxt == PERSIST_C) state_d = S_LOW;
          else                          state_d = S_NORMAL;
        end
        S_HIGH:  if (exit_hi) state_d = S_NORMAL;
        S_LOW:   if (exit_lo) state_d = S_NORMAL;
        default: state_d = S_INIT;
      endcase
    end

    // The counter of the active alarm direction is parked at zero while in that alarm.
    hi_cnt_d = (state_d == S_HIGH) ? '0 : hi_nxt;
    lo_cnt_d = (state_d == S_LOW)  ? '0 : lo_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_INIT;
      hi_cnt_q     <= '0;
      lo_cnt_q     <= '0;
      in_range_q   <= 1'b0;
      alarm_hi_q   <= 1'b0;
      alarm_lo_q   <= 1'b0;
      cfg_err_q    <= 1'b0;
      dout_valid_q <= 1'b0;
      evt_q        <= 1'b0;
      evt_code_q   <= 2'd0;
    end else if (din_valid) begin
      state_q      <= state_d;
      hi_cnt_q     <= hi_cnt_d;
      lo_cnt_q     <= lo_cnt_d;
      in_range_q   <= (state_d == S_NORMAL);
      alarm_hi_q   <= (state_d == S_HIGH);
      alarm_lo_q   <= (state_d == S_LOW);
      cfg_err_q    <= cfg_bad;
      dout_valid_q <= 1'b1;
      evt_q        <= (state_d != state_q);
      if (state_d != state_q) evt_code_q <= state_d;
    end else begin
      dout_valid_q <= 1'b0;
      evt_q        <= 1'b0;
    end
  end

  assign in_range   = in_range_q;
  assign alarm_hi   = alarm_hi_q;
  assign alarm_lo   = alarm_lo_q;
  assign cfg_err    = cfg_err_q;
  assign dout_valid = dout_valid_q;
  assign evt        = evt_q;
  assign evt_code   = evt_code_q;

endmodule

// File: tb/tb_threshold_monitor.sv
// tb/tb_threshold_monitor.sv - directed self-checking bench for threshold_monitor
module tb_threshold_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din_valid = 1'b0;
  logic [3:0] din = 4'd0;
  logic       din_valid_h0 = 1'b0;
  logic [3:0] din_h0 = 4'd0;
  logic [3:0] thr_hi = 4'd10;
  logic [3:0] thr_lo = 4'd3;

  logic       in_range, alarm_hi, alarm_lo, cfg_err, dout_valid, evt;
  logic [1:0] evt_code;
  logic       in_range_h0, alarm_hi_h0, alarm_lo_h0, cfg_err_h0, dout_valid_h0, evt_h0;
  logic [1:0] evt_code_h0;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  threshold_monitor #(.WIDTH(4), .PERSIST(3), .HYST(2)) u_dut (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din),
    .thr_hi(thr_hi), .thr_lo(thr_lo),
    .in_range(in_range), .alarm_hi(alarm_hi), .alarm_lo(alarm_lo),
    .cfg_err(cfg_err), .dout_valid(dout_valid), .evt(evt), .evt_code(evt_code)
  );

  threshold_monitor #(.WIDTH(4), .PERSIST(3), .HYST(0)) u_dut_h0 (
    .clk(clk), .rst(rst), .din_valid(din_valid_h0), .din(din_h0),
    .thr_hi(thr_hi), .thr_lo(thr_lo),
    .in_range(in_range_h0), .alarm_hi(alarm_hi_h0), .alarm_lo(alarm_lo_h0),
    .cfg_err(cfg_err_h0), .dout_valid(dout_valid_h0), .evt(evt_h0), .evt_code(evt_code_h0)
  );

  // Packed view: {in_range, alarm_hi, alarm_lo, cfg_err, dout_valid, evt, evt_code[1:0]}
  function automatic logic [7:0] outs();
    return {in_range, alarm_hi, alarm_lo, cfg_err, dout_valid, evt, evt_code};
  endfunction

  function automatic logic [7:0] outs_h0();
    return {in_range_h0, alarm_hi_h0, alarm_lo_h0, cfg_err_h0, dout_valid_h0, evt_h0, evt_code_h0};
  endfunction

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the next negedge with that sample's result visible.
  task automatic send(input logic [3:0] d, input bit to_main = 1'b1, input bit to_h0 = 1'b0);
    din          = d;
    din_valid    = to_main;
    din_h0       = d;
    din_valid_h0 = to_h0;
    @(negedge clk);
    din_valid    = 1'b0;
    din_valid_h0 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Valid is held high during reset to show reset wins.
  task automatic do_reset();
    rst          = 1'b1;
    din          = 4'd11;
    din_valid    = 1'b1;
    din_valid_h0 = 1'b1;
    @(negedge clk);
    rst          = 1'b0;
    din_valid    = 1'b0;
    din_valid_h0 = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // 1: reset state and first sample
    idle(5);
    check_eq("s1_reset_idle", outs(), 8'b0000_0000);
    send(4'd5);
    check_eq("s1_first_normal", outs(), 8'b1000_1101);
    idle(1);
    check_eq("s1_idle_hold", outs(), 8'b1000_0001);

    // 2: persistence, run break, gaps
    send(4'd11);
    check_eq("s2_hi1", outs(), 8'b1000_1001);
    send(4'd12);
    send(4'd11);
    check_eq("s2_enter_high", outs(), 8'b0100_1110);
    send(4'd8);
    check_eq("s2_back_normal", outs(), 8'b1000_1101);
    send(4'd11); send(4'd12); send(4'd5); send(4'd11);
    send(4'd12);
    check_eq("s2_broken_run", outs(), 8'b1000_1001);
    send(4'd5);
    send(4'd11);
    idle(4);
    check_eq("s2_gap_hold", outs(), 8'b1000_0001);
    send(4'd12);
    check_eq("s2_gap_cnt2", outs(), 8'b1000_1001);
    send(4'd11);
    check_eq("s2_gap_high", outs(), 8'b0100_1110);

    // 3: hysteresis exits
    send(4'd9);
    check_eq("s3_hi_stay", outs(), 8'b0100_1010);
    send(4'd8);
    check_eq("s3_hi_exit", outs(), 8'b1000_1101);
    send(4'd2);
    send(4'd2);
    check_eq("s3_lo_cnt2", outs(), 8'b1000_1001);
    send(4'd2);
    check_eq("s3_enter_low", outs(), 8'b0010_1111);
    send(4'd4);
    check_eq("s3_lo_stay", outs(), 8'b0010_1011);
    send(4'd5);
    check_eq("s3_lo_exit", outs(), 8'b1000_1101);

    // 4: top-of-range thresholds, no wrap in exit test
    do_reset();
    thr_lo = 4'd14;
    thr_hi = 4'd15;
    send(4'd13, 1'b1, 1'b1);
    check_eq("s4_init_normal", outs(), 8'b1000_1101);
    send(4'd13, 1'b1, 1'b1);
    send(4'd13, 1'b1, 1'b1);
    check_eq("s4_enter_low", outs(), 8'b0010_1111);
    check_eq("s4_h0_enter_low", outs_h0(), 8'b0010_1111);
    send(4'd15);
    check_eq("s4_no_wrap_1", outs(), 8'b0010_1011);
    send(4'd15);
    check_eq("s4_no_wrap_2", outs(), 8'b0010_1011);
    send(4'd14, 1'b0, 1'b1);
    check_eq("s4_h0_exit", outs_h0(), 8'b1000_1101);

    // 5: illegal threshold pair
    do_reset();
    thr_lo = 4'd3;
    thr_hi = 4'd10;
    send(4'd5);
    send(4'd11);
    send(4'd11);
    check_eq("s5_pre_cnt2", outs(), 8'b1000_1001);
    thr_lo = 4'd9;
    thr_hi = 4'd4;
    send(4'd12);
    check_eq("s5_cfg_err", outs(), 8'b1001_1001);
    thr_lo = 4'd3;
    thr_hi = 4'd10;
    send(4'd6);
    check_eq("s5_cfg_clear", outs(), 8'b1000_1001);
    send(4'd11);
    send(4'd11);
    check_eq("s5_cnt_restart", outs(), 8'b1000_1001);
    send(4'd11);
    check_eq("s5_high_after", outs(), 8'b0100_1110);

    // 6: reset mid-run
    do_reset();
    send(4'd11);
    send(4'd11);
    check_eq("s6_pre_reset", outs(), 8'b1000_1001);
    do_reset();
    check_eq("s6_after_reset", outs(), 8'b0000_0000);
    send(4'd11);
    check_eq("s6_normal_only", outs(), 8'b1000_1101);
    send(4'd11);
    check_eq("s6_cnt2_only", outs(), 8'b1000_1001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/threshold_monitor.md
Name: threshold_monitor

Overview:
- Streaming magnitude monitor placed directly downstream of the 4-bit magnitude comparator.
- Each valid sample is compared against programmable high and low thresholds, using the same greater/equal/less semantics as that comparator.
- A persistence filter and a hysteresis band drive a 4-state alarm FSM.
- Outputs are registered status flags plus a one-cycle event pulse, for consumption by control logic.

Parameters:
- WIDTH, 4, sample and threshold width in bits (unsigned).
- PERSIST, 3, number of consecutive qualifying valid samples needed to enter an alarm state. Legal range is >=1.
- HYST, 2, hysteresis margin in LSBs applied on alarm exit. Legal range is 0..2^WIDTH-1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- din_valid  in  1  qualifies din; sample accepted on the clock edge where this is 1.
- din  in  WIDTH  unsigned sample.
- thr_hi  in  WIDTH  high threshold, sampled together with din.
- thr_lo  in  WIDTH  low threshold, sampled together with din.
- in_range  out  1  FSM in NORMAL.
- alarm_hi  out  1  FSM in HIGH.
- alarm_lo  out  1  FSM in LOW.
- cfg_err  out  1  last accepted sample had thr_lo > thr_hi.
- dout_valid  out  1  one-cycle pulse, one cycle after each accepted sample.
- evt  out  1  one-cycle pulse on every FSM state change.
- evt_code  out  2  state entered: 0=INIT, 1=NORMAL, 2=HIGH, 3=LOW. Valid only while evt=1; holds its value otherwise.

Behaviour:
- Reset (rst=1 at edge):
  - FSM to INIT; hi_cnt=lo_cnt=0.
  - All outputs 0, evt_code=0.
  - rst has priority over din_valid.
- Per accepted sample, with comparisons unsigned:
  - gt = din > thr_hi
  - lt = din < thr_lo
- Exit tests are evaluated in WIDTH+1 bits, so there is no wrap:
  - exit_hi = (din + HYST) <= thr_hi
  - exit_lo = din >= (thr_lo + HYST)
- Counters (updated only on accepted samples):
  - hi_cnt = gt ? min(hi_cnt+1, PERSIST) : 0.
  - lo_cnt = lt ? min(lo_cnt+1, PERSIST) : 0.
  - Cycles with din_valid=0 hold the counters and the FSM unchanged. Gaps do not break a run.
- Config error: if thr_lo > thr_hi, the sample is counted as neither gt nor lt.
  - Counters clear to 0, the FSM holds, cfg_err=1.
  - cfg_err clears on the next accepted sample with legal thresholds.
- FSM transitions (next-count values used):
  - INIT: the first accepted legal sample goes to NORMAL. That sample also updates the counters. If it already reaches PERSIST (only possible when PERSIST=1), go directly to HIGH or LOW instead.
  - NORMAL: if hi_cnt_next==PERSIST go to HIGH; else if lo_cnt_next==PERSIST go to LOW. gt and lt cannot both hold when thresholds are legal.
  - HIGH: if exit_hi go to NORMAL; otherwise stay. While in HIGH, hi_cnt is forced to 0.
  - LOW: if exit_lo go to NORMAL; otherwise stay. While in LOW, lo_cnt is forced to 0.
  - No direct HIGH<->LOW transition. A sample that exits HIGH and also satisfies lt lands in NORMAL with lo_cnt=1.
- Timing:
  - Latency is one cycle. Flags, dout_valid, evt and evt_code update on the edge that accepts the sample and are visible in the following cycle.
  - Back-to-back valid samples are supported at full rate. dout_valid may stay high continuously.
  - evt=1 exactly in cycles where the state flags differ from the previous cycle, excluding reset.
  - in_range, alarm_hi and alarm_lo are one-hot, or all 0 in INIT.
- Implementation note: the comparison datapath may instantiate the team's 4-bit comparator when WIDTH=4. Behaviour must not depend on that choice.

Test Plan:
- Defaults for all scenarios: WIDTH=4, PERSIST=3, HYST=2, thr_hi=10, thr_lo=3 unless stated.
1. Reset, then 5 idle cycles → all outputs 0. Then din=5 valid → next cycle in_range=1, dout_valid=1, evt=1, evt_code=1.
2. From NORMAL, valid samples 11,12,11 → alarm_hi=1 with evt_code=2 in the cycle after the third sample. Sequence 11,12,5,11,12 → no alarm, in_range stays 1. Sequence 11,(gap of 4 idle cycles),12,11 → alarm_hi after the last sample.
3. In HIGH: din=9 → stays HIGH (9+2=11>10). Then din=8 → NORMAL, evt_code=1. Then 2,2,2 → LOW after the third sample. Then 4 → stays LOW; then 5 → NORMAL.
4. Boundary, no wrap: thr_lo=14, thr_hi=15; drive 13 three times → LOW. Then 15 and 15 → stays LOW, because 15 >= 16 is false in 5 bits. HYST=0 variant: 14 → NORMAL.
5. Illegal config, thr_lo=9, thr_hi=4: din=12 → cfg_err=1, FSM holds, no evt. Then legal thresholds with din=6 → cfg_err=0. Confirm the counters restarted from 0.
6. Reset mid-run: two samples of 11, then rst=1 for one cycle → all outputs 0 next cycle. Then one sample of 11 → NORMAL only (count restarted), no alarm.
